stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Sequencing controller for the 8-digit BCD counter and multiplexed seven-segment display. Conditions three push-buttons (start/stop, lap, clear), runs an IDLE/RUN/PAUSE state machine, generates the counter's one-cycle `enable` tick and a one-cycle clear pulse, and selects the display source: the live count or a frozen lap value. Sits between the board buttons and the counter/display scanner in the top level.

## Interface
- `TICK_DIV`, 500000: clk cycles per count tick (10 ms at 50 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable synchronized samples required before a press is accepted; must be ≥ 1.
- `clk`  in  1: single clock for all logic.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `btn_start`  in  1: raw start/stop button, active-high, asynchronous to `clk`.
- `btn_lap`  in  1: raw lap button, active-high, asynchronous.
- `btn_clear`  in  1: raw clear button, active-high, asynchronous.
- `count_value`  in  32: packed BCD count from the counter; digit0 is `[3:0]`.
- `cnt_enable`  out  1: one-cycle tick to the counter's `enable`.
- `cnt_clear`  out  1: one-cycle pulse to the counter's synchronous `reset`.
- `disp_value`  out  32: BCD value for the display scanner.
- `running`  out  1: high in RUN.
- `lap_active`  out  1: display frozen on the lap value.
- `sat`  out  1: the count has saturated at 99999999.

## Operation
- Button conditioning, per button: 2-flop synchronizer, then a debounce counter. A press is accepted after the synchronized level has been high for `DEBOUNCE_CYCLES` consecutive cycles. Each accepted press yields exactly one 1-cycle pulse (`p_start`, `p_lap`, `p_clear`). A held button produces no repeat pulses. A new press requires a release that is stable for `DEBOUNCE_CYCLES` cycles.
- States:
  - IDLE: count 0, stopped.
  - RUN: prescaler counting.
  - PAUSE: stopped, count held.
- Priority within a cycle: `p_clear` > `p_start` > `p_lap`. A lower-priority pulse in the same cycle is dropped if a higher one acts; an ignored higher pulse does not block lower ones.
- IDLE:
  - `p_clear` asserts `cnt_clear` and stays in IDLE.
  - `p_start` goes to RUN.
  - `p_lap` is ignored.
- RUN:
  - `p_clear` is ignored.
  - `p_start` goes to PAUSE.
  - `p_lap` toggles lap freeze. Entering freeze captures `count_value` into `lap_reg`. The counter keeps running.
- PAUSE:
  - `p_clear` asserts `cnt_clear`, clears freeze, `sat` and the prescaler, and goes to IDLE.
  - `p_start` goes to RUN.
  - `p_lap` clears freeze.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 and wraps, only in RUN.
  - Holds its value in PAUSE, so the phase is kept across pause and resume.
  - Is 0 in IDLE.
  - `cnt_enable` = 1 for the cycle in which the state is RUN and the prescaler equals `TICK_DIV`-1.
- Saturation: in RUN, if `count_value` == 32'h99999999 and a tick is due, the tick is suppressed, `sat` is set and the state goes to PAUSE. While `sat` is set, `p_start` is ignored; only clear exits.
- `disp_value` = `lap_active` ? `lap_reg` : `count_value`.

## Timing
- Reset (async assert, sync release): state IDLE, prescaler 0, `cnt_enable` 0, `cnt_clear` 0, `lap_active` 0, `lap_reg` 0, `running` 0, `sat` 0. The debounce counters and synchronizers are cleared to the released state.
- Reset mid-run: takes effect immediately. The counter is not cleared by the controller's reset; the top level also resets the counter.
- Press latency: the raw edge leads to a pulse after 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- The FSM updates on the edge where the pulse is high. `running` and `lap_active` are registered and reflect the new state one cycle after the pulse.
- `cnt_clear` is registered: high in the cycle after `p_clear`, for exactly 1 cycle.
- `cnt_enable` is registered:
  - First tick after RUN entry from IDLE: `TICK_DIV` cycles after the state register shows RUN.
  - Steady-state period: `TICK_DIV`.
- `lap_reg` captures `count_value` as sampled on the `p_lap` edge. `disp_value` is combinational from the registers and `count_value`.

## Structure
- Shared package `stopwatch_pkg`: state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2) and the BCD saturation constant 32'h99999999.
- Sub-module `button_cond` (synchronizer, debounce and rising-edge pulse; parameter `DEBOUNCE_CYCLES`), instantiated 3×.
- The FSM, prescaler, lap register and output mux live in `stopwatch_ctrl`.

## Test plan
All scenarios use `TICK_DIV`=4 and `DEBOUNCE_CYCLES`=3.
- Reset, then 10 idle cycles -> all outputs 0, and no `cnt_enable` or `cnt_clear` pulses.
- Start press held 20 cycles -> exactly one `p_start`, `running`=1, `cnt_enable` every 4 cycles. A 2-cycle glitch on the button produces no pulse.
- In RUN, press start -> PAUSE, `cnt_enable` stops. Resume -> the next tick arrives after the remaining prescaler count, and the phase is preserved.
- In RUN with the counter model at 32'h00000042, press lap -> `disp_value`=32'h00000042 while `count_value` advances. A second lap press returns `disp_value` to live.
- In PAUSE, assert clear and start simultaneously -> one `cnt_clear` pulse, state IDLE, start dropped, `lap_active`=0.
- Counter model at 32'h99999999 in RUN -> no further `cnt_enable`, `sat`=1, state PAUSE, start ignored. Clear -> `sat`=0, IDLE. `reset_n` low mid-RUN -> outputs are at their reset values before the next clock edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Largest value the 8-digit BCD counter can show.
  localparam logic [31:0] BCD_MAX = 32'h9999_9999;

endpackage

// File: rtl/stopwatch_ctrl_button_cond.sv
// Push-button conditioner: 2-flop synchronizer, debounce, one-cycle press pulse.
module button_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          pulse_q, pulse_d;

  // Debounced level flips only after the synchronized input has disagreed
  // with it for DEBOUNCE_CYCLES consecutive samples; a rising flip makes one pulse.
  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    cnt_d       = '0;
    level_d     = level_q;
    level_dly_d = level_q;
    pulse_d     = level_q & ~level_dly_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Conditioner registers, cleared to the released state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button handling, IDLE/RUN/PAUSE FSM,
// count-tick prescaler, lap freeze and display source selection.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV        = 500000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic [31:0] count_value,
  output logic        cnt_enable,
  output logic        cnt_clear,
  output logic [31:0] disp_value,
  output logic        running,
  output logic        lap_active,
  output logic        sat
);

  import stopwatch_pkg::*;

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic p_start, p_lap, p_clear;

  button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_start), .pulse(p_start)
  );
  button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_lap), .pulse(p_lap)
  );
  button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_clear), .pulse(p_clear)
  );

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_enable_q, cnt_enable_d;
  logic          cnt_clear_q, cnt_clear_d;
  logic          lap_active_q, lap_active_d;
  logic [31:0]   lap_reg_q, lap_reg_d;
  logic          running_q, running_d;
  logic          sat_q, sat_d;
  logic          tick_due, sat_hit;

  // Next-state logic; within a cycle clear beats start beats lap, and a
  // pulse that is ignored in the current state does not block lower ones.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_enable_d = 1'b0;
    cnt_clear_d  = 1'b0;
    lap_active_d = lap_active_q;
    lap_reg_d    = lap_reg_q;
    sat_d        = sat_q;
    tick_due     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    sat_hit      = tick_due && (count_value == BCD_MAX);
    unique case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (p_clear) begin
          cnt_clear_d = 1'b1;
        end else if (p_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        presc_d      = tick_due ? '0 : presc_q + 1'b1;
        cnt_enable_d = tick_due & ~sat_hit;
        if (sat_hit) begin
          sat_d   = 1'b1;
          state_d = ST_PAUSE;
        end
        if (p_start) begin
          state_d = ST_PAUSE;
        end else if (p_lap) begin
          lap_active_d = ~lap_active_q;
          if (!lap_active_q) lap_reg_d = count_value;
        end
      end
      ST_PAUSE: begin
        if (p_clear) begin
          cnt_clear_d  = 1'b1;
          lap_active_d = 1'b0;
          sat_d        = 1'b0;
          presc_d      = '0;
          state_d      = ST_IDLE;
        end else if (p_start && !sat_q) begin
          state_d = ST_RUN;
        end else if (p_lap) begin
          lap_active_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
    running_d = (state_d == ST_RUN);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      cnt_enable_q <= 1'b0;
      cnt_clear_q  <= 1'b0;
      lap_active_q <= 1'b0;
      lap_reg_q    <= '0;
      running_q    <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_clear_q  <= cnt_clear_d;
      lap_active_q <= lap_active_d;
      lap_reg_q    <= lap_reg_d;
      running_q    <= running_d;
      sat_q        <= sat_d;
    end
  end

  assign cnt_enable = cnt_enable_q;
  assign cnt_clear  = cnt_clear_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign sat        = sat_q;
  assign disp_value = lap_active_q ? lap_reg_q : count_value;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button activity,
// checked every cycle against a behavioural model and a BCD counter model.
module tb_stopwatch_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned DB = 3;
  localparam logic [31:0] TOP = 32'h9999_9999;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
  logic [31:0] cnt_val;
  logic        cnt_enable, cnt_clear, running, lap_active, sat;
  logic [31:0] disp_value;

  int tests = 0;
  int fails = 0;
  int preset_seq = 0;
  int preset_seen = 0;
  logic [31:0] preset_val = '0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .count_value(cnt_val),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .disp_value(disp_value),
    .running(running), .lap_active(lap_active), .sat(sat)
  );

  function automatic logic [31:0] bcd_inc(logic [31:0] v);
    int n = 0;
    logic [31:0] r = '0;
    for (int i = 7; i >= 0; i--) n = n * 10 + int'(v[i*4 +: 4]);
    n = n + 1;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  // Board counter model (reset together with the controller), with test presets.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_val <= '0;
    else if (preset_seq != preset_seen) begin
      cnt_val     <= preset_val;
      preset_seen <= preset_seq;
    end
    else if (cnt_clear)  cnt_val <= '0;
    else if (cnt_enable) cnt_val <= bcd_inc(cnt_val);
  end

  // Reference model. mode: 0 stopped at zero, 1 counting, 2 held.
  typedef struct packed {
    logic [1:0]      mode;
    logic [31:0]     presc;
    logic            lap;
    logic [31:0]     lapv;
    logic            sat;
    logic            en;
    logic            clr;
    logic            run;
    logic [2:0][7:0] h;      // raw samples per button, [0] most recent
    logic [2:0]      lvl;    // accepted button level
    logic [2:0]      rose;   // level went high at the previous edge
    logic [2:0]      pulse;  // press pulse visible this cycle
  } model_t;

  function automatic model_t step(model_t s, logic [2:0] raw, logic [31:0] cv);
    model_t n = s;
    logic ps, pl, pc, all_diff, due;
    ps = s.pulse[0];
    pl = s.pulse[1];
    pc = s.pulse[2];
    for (int b = 0; b < 3; b++) begin
      // a level change needs DB consecutive synchronized samples that disagree
      all_diff = 1'b1;
      for (int unsigned i = 1; i <= DB; i++) if (s.h[b][i] == s.lvl[b]) all_diff = 1'b0;
      n.pulse[b] = s.rose[b];
      n.rose[b]  = all_diff & ~s.lvl[b];
      if (all_diff) n.lvl[b] = ~s.lvl[b];
      n.h[b] = {s.h[b][6:0], raw[b]};
    end
    n.en  = 1'b0;
    n.clr = 1'b0;
    case (s.mode)
      2'd0: begin
        n.presc = 0;
        if (pc) n.clr = 1'b1;
        else if (ps) n.mode = 2'd1;
      end
      2'd1: begin
        due     = (s.presc == TD - 1);
        n.presc = (s.presc + 1) % TD;
        if (due && cv == TOP) begin
          n.sat  = 1'b1;
          n.mode = 2'd2;
        end else if (due) n.en = 1'b1;
        if (ps) n.mode = 2'd2;
        else if (pl) begin
          if (!s.lap) n.lapv = cv;
          n.lap = ~s.lap;
        end
      end
      2'd2: begin
        if (pc) begin
          n.clr = 1'b1; n.lap = 1'b0; n.sat = 1'b0; n.presc = 0; n.mode = 2'd0;
        end else if (ps && !s.sat) n.mode = 2'd1;
        else if (pl) n.lap = 1'b0;
      end
      default: ;
    endcase
    n.run = (n.mode == 2'd1);
    return n;
  endfunction

  model_t m;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else m <= step(m, {btn_clear, btn_lap, btn_start}, cnt_val);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("cnt_enable", 32'(cnt_enable), 32'(m.en));
    chk("cnt_clear",  32'(cnt_clear),  32'(m.clr));
    chk("running",    32'(running),    32'(m.run));
    chk("lap_active", 32'(lap_active), 32'(m.lap));
    chk("sat",        32'(sat),        32'(m.sat));
    chk("disp_value", disp_value, m.lap ? m.lapv : cnt_val);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic preset(input logic [31:0] v);
    preset_val = v;
    preset_seq++;
  endtask

  task automatic press(input int b, input int hold, input int gap);
    if (b == 0) btn_start = 1'b1; else if (b == 1) btn_lap = 1'b1; else btn_clear = 1'b1;
    cyc(hold);
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    cyc(gap);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_lap"},     32'(lap_active), 32'd0);
    chk({tag, "_sat"},     32'(sat), 32'd0);
    chk({tag, "_en"},      32'(cnt_enable), 32'd0);
    chk({tag, "_clr"},     32'(cnt_clear), 32'd0);
    chk({tag, "_disp"},    disp_value, 32'd0);
  endtask

  initial begin
    logic [31:0] rv;
    // Reset and idle
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_reset_vals("reset");
    cyc(10);

    // Long start press, then a short glitch that must not register
    btn_start = 1'b1;
    cyc(20);
    btn_start = 1'b0;
    cyc(8);
    chk("run_after_start", 32'(running), 32'd1);
    btn_start = 1'b1;
    cyc(2);
    btn_start = 1'b0;
    cyc(10);
    chk("run_after_glitch", 32'(running), 32'd1);

    // Pause, wait an odd number of cycles, resume
    press(0, 8, 3);
    chk("paused", 32'(running), 32'd0);
    cyc(11);
    press(0, 8, 12);

    // Lap freeze with the counter at 0x42 on the capture edge
    btn_lap = 1'b1;
    cyc(5);
    preset(32'h0000_0042);
    cyc(2);
    chk("lap_freeze", disp_value, 32'h0000_0042);
    chk("lap_on", 32'(lap_active), 32'd1);
    cyc(10);
    btn_lap = 1'b0;
    cyc(6);
    chk("lap_held", disp_value, 32'h0000_0042);
    press(1, 8, 8);
    chk("lap_off", 32'(lap_active), 32'd0);
    chk("lap_live", disp_value, cnt_val);

    // Freeze, pause, then clear and start together
    press(1, 8, 8);
    press(0, 8, 8);
    btn_clear = 1'b1;
    btn_start = 1'b1;
    cyc(8);
    btn_clear = 1'b0;
    btn_start = 1'b0;
    cyc(8);
    chk("clr_start_run", 32'(running), 32'd0);
    chk("clr_start_lap", 32'(lap_active), 32'd0);
    chk("clr_start_disp", disp_value, 32'd0);

    // Saturation
    press(0, 8, 3);
    preset(TOP);
    cyc(12);
    chk("sat_set", 32'(sat), 32'd1);
    chk("sat_stopped", 32'(running), 32'd0);
    chk("sat_disp", disp_value, TOP);
    press(0, 8, 8);
    chk("sat_start_ignored", 32'(running), 32'd0);
    press(2, 8, 8);
    chk("sat_cleared", 32'(sat), 32'd0);
    chk("sat_clear_disp", disp_value, 32'd0);

    // Asynchronous reset while running
    press(0, 8, 7);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    cyc(2);
    reset_n = 1'b1;
    cyc(5);

    // Random button activity and counter presets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 7) == 0) btn_lap   = ~btn_lap;
      if ($urandom_range(0, 9) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 2))
          0: rv = TOP;
          1: rv = 32'h9999_9997;
          default: for (int d = 0; d < 8; d++) rv[d*4 +: 4] = 4'($urandom_range(0, 9));
        endcase
        preset(rv);
      end
      cyc(1);
    end
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
